systolic_drain: RTL and testbench

//  Result-side counterpart of the systolic operand feeder. Snapshots the N x N result

---
 rtl/systolic_drain_pkg.sv | 19 +
 rtl/systolic_drain_rise_detect.sv | 21 ++
 rtl/systolic_drain.sv | 138 +++++++++++++
 tb/tb_systolic_drain.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_drain_pkg.sv
// Shared types and index helpers for the systolic result drain.
package systolic_drain_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  // Width of a row/col index. It is never below 1, so N=1 still gets a real port.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Flat element number of (row, col) inside the packed result matrix.
  function automatic int elem_sel(input int row, input int col, input int n);
    return row * n + col;
  endfunction

endpackage

// File: rtl/systolic_drain_rise_detect.sv
// Registered rising-edge detector with a synchronous active-low reset.
// o_q is the delayed copy of i_sig and is exposed so the parent can reuse it.
module systolic_drain_rise_detect (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sig,
  output logic o_rise,
  output logic o_q
);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_q <= 1'b0;
    end else begin
      o_q <= i_sig;
    end
  end

  assign o_rise = i_sig & ~o_q;

endmodule

// File: rtl/systolic_drain.sv
// Snapshots the N x N result matrix on a rising i_done and streams it out one element per beat.
// Build option DRAIN_COLMAJOR_EN: column-major streaming order (row-major when undefined).
//
// Handshake: a beat transfers on a clock edge where o_valid && i_ready. While o_valid is high
// and i_ready is low, o_data/o_row/o_col/o_last stay stable. o_valid only drops after the
// last beat has been accepted.
module systolic_drain
  import systolic_drain_pkg::*;
#(
  parameter  int W    = 16,
  parameter  int N    = 3,
  localparam int IDXW = idx_w(N)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [W*N*N-1:0]  i_C,
  input  logic              i_done,
  output logic [W-1:0]      o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [IDXW-1:0]   o_row,
  output logic [IDXW-1:0]   o_col,
  output logic              o_last,
  output logic              o_busy,
  output logic              o_overrun,
  output logic              o_state
);

  localparam logic [IDXW-1:0] MAX_IDX = IDXW'(N - 1);
  localparam logic [IDXW-1:0] ONE_IDX = IDXW'(1);
  localparam logic            SINGLE  = (N == 1);

  state_t            state_q;
  logic [W*N*N-1:0]  buf_q;
  logic [IDXW-1:0]   row_q;
  logic [IDXW-1:0]   col_q;
  logic              done_q;
  logic              rise;
  logic              accept;
  logic [IDXW-1:0]   nxt_row;
  logic [IDXW-1:0]   nxt_col;
  logic              nxt_last;
  logic [W-1:0]      nxt_data;
  int                nxt_sel;

  systolic_drain_rise_detect u_rise (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_sig   (i_done),
    .o_rise  (rise),
    .o_q     (done_q)
  );

  assign accept  = o_valid & i_ready;
  assign o_row   = row_q;
  assign o_col   = col_q;
  assign o_state = state_q;

  // Coordinates and data of the beat that follows the one currently presented.
  always_comb begin
    nxt_row  = row_q;
    nxt_col  = col_q;
    nxt_data = '0;
`ifdef DRAIN_COLMAJOR_EN
    if (row_q == MAX_IDX) begin
      nxt_row = '0;
      nxt_col = col_q + ONE_IDX;
    end else begin
      nxt_row = row_q + ONE_IDX;
    end
`else
    if (col_q == MAX_IDX) begin
      nxt_col = '0;
      nxt_row = row_q + ONE_IDX;
    end else begin
      nxt_col = col_q + ONE_IDX;
    end
`endif
    nxt_last = (nxt_row == MAX_IDX) && (nxt_col == MAX_IDX);
    nxt_sel  = elem_sel(int'(nxt_row), int'(nxt_col), N);
    for (int k = 0; k < N * N; k++) begin
      if (k == nxt_sel) begin
        nxt_data = buf_q[k*W +: W];
      end
    end
  end

  // Outputs are registered so the presented beat can only change on an accept.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      buf_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      o_data    <= '0;
      o_valid   <= 1'b0;
      o_last    <= 1'b0;
      o_busy    <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      // A rise while streaming, including on the final accept, drops that snapshot.
      o_overrun <= rise && (state_q == ST_STREAM);
      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            state_q <= ST_STREAM;
            buf_q   <= i_C;
            row_q   <= '0;
            col_q   <= '0;
            o_data  <= i_C[W-1:0];
            o_valid <= 1'b1;
            o_last  <= SINGLE;
            o_busy  <= 1'b1;
          end
        end
        ST_STREAM: begin
          if (accept) begin
            if (o_last) begin
              state_q <= ST_IDLE;
              row_q   <= '0;
              col_q   <= '0;
              o_data  <= '0;
              o_valid <= 1'b0;
              o_last  <= 1'b0;
              o_busy  <= 1'b0;
            end else begin
              row_q  <= nxt_row;
              col_q  <= nxt_col;
              o_data <= nxt_data;
              o_last <= nxt_last;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_drain.sv
// Directed bench for systolic_drain (W=16, N=3) with a queue-based scoreboard.
module tb_systolic_drain;

  localparam int W    = 16;
  localparam int N    = 3;
  localparam int IDXW = 2;
  localparam int BW   = W + 2 * IDXW + 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [W*N*N-1:0]   c_mat;
  logic               done;
  logic               ready;
  logic [W-1:0]       o_data;
  logic               o_valid;
  logic [IDXW-1:0]    o_row;
  logic [IDXW-1:0]    o_col;
  logic               o_last;
  logic               o_busy;
  logic               o_overrun;
  logic               dbg_state;

  logic [BW-1:0]      exp_q[$];
  int                 n_chk = 0;
  int                 n_err = 0;
  int                 acc_cnt = 0;
  int                 ovr_cnt = 0;
  logic               stalled = 1'b0;
  logic [BW-1:0]      held;

  // Hand-computed element order for each build.
`ifdef DRAIN_COLMAJOR_EN
  logic [15:0] order [9] = '{16'd1, 16'd4, 16'd7, 16'd2, 16'd5, 16'd8, 16'd3, 16'd6, 16'd9};
`else
  logic [15:0] order [9] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
`endif

  systolic_drain #(.W(W), .N(N)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_C       (c_mat),
    .i_done    (done),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .i_ready   (ready),
    .o_row     (o_row),
    .o_col     (o_col),
    .o_last    (o_last),
    .o_busy    (o_busy),
    .o_overrun (o_overrun),
    .o_state   (dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_matrix();
    for (int k = 0; k < N * N; k++) c_mat[k*W +: W] = 16'(k + 1);
  endtask

  task automatic push_matrix();
    logic [15:0] d;
    logic [IDXW-1:0] r;
    logic [IDXW-1:0] c;
    for (int i = 0; i < 9; i++) begin
      d = order[i];
      r = IDXW'((d - 16'd1) / 16'd3);
      c = IDXW'((d - 16'd1) % 16'd3);
      exp_q.push_back({d, r, c, (d == 16'd9)});
    end
  endtask

  task automatic wait_accepts(input int target, input int budget, input string name);
    int n = 0;
    while (acc_cnt < target && n < budget) begin
      tick();
      n++;
    end
    chk(name, acc_cnt, target);
  endtask

  // Scoreboard monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    logic [BW-1:0] cur;
    logic [BW-1:0] e;
    cur = {o_data, o_row, o_col, o_last};
    if (rst_n && stalled) begin
      chk("hold_valid", o_valid, 1'b1);
      chk("hold_beat", cur, held);
    end
    stalled = rst_n && o_valid && !ready;
    held    = cur;
    if (rst_n && o_valid && ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL beat_unexpected: act=%0h exp=none", cur);
      end else begin
        e = exp_q.pop_front();
        chk("beat", cur, e);
      end
      acc_cnt++;
    end
    if (o_overrun) ovr_cnt++;
  end

  initial begin
    int base;
    rst_n = 1'b0;
    done  = 1'b0;
    ready = 1'b0;
    load_matrix();
    tick();
    tick();
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_overrun", o_overrun, 1'b0);
    chk("rst_outs", {o_data, o_row, o_col, o_last}, '0);
    rst_n = 1'b1;
    tick();

    // 1: full-rate burst, latency and o_last placement
    base = acc_cnt;
    push_matrix();
    ready = 1'b1;
    done  = 1'b1;
    chk("valid_pre", o_valid, 1'b0);
    tick();
    chk("valid_lat", o_valid, 1'b1);
    chk("busy_on", o_busy, 1'b1);
    repeat (9) tick();
    chk("burst_len", acc_cnt, base + 9);
    chk("valid_drop", o_valid, 1'b0);
    chk("busy_off", o_busy, 1'b0);
    done = 1'b0;
    tick();

    // 2: ready pattern 1,0,0,1 stalls
    base = acc_cnt;
    push_matrix();
    done = 1'b1;
    for (int i = 0; i < 60 && acc_cnt < base + 9; i++) begin
      ready = ((i % 4) == 0) || ((i % 4) == 3);
      tick();
    end
    chk("stall_count", acc_cnt, base + 9);
    ready = 1'b1;
    done  = 1'b0;
    tick();

    // 3: i_C changes after capture are ignored
    base = acc_cnt;
    push_matrix();
    done = 1'b1;
    tick();
    c_mat = '1;
    wait_accepts(base + 9, 30, "frozen_count");
    load_matrix();
    done = 1'b0;
    tick();

    // 4: rearm mid-stream gives one overrun pulse and no second stream
    base = acc_cnt;
    push_matrix();
    done = 1'b1;
    tick();
    wait_accepts(base + 4, 20, "pre_ovr_count");
    done = 1'b0;
    tick();
    done = 1'b1;
    tick();
    chk("ovr_pulse", o_overrun, 1'b1);
    tick();
    chk("ovr_one_cycle", o_overrun, 1'b0);
    wait_accepts(base + 9, 20, "post_ovr_count");
    repeat (12) tick();
    chk("no_restart", acc_cnt, base + 9);
    chk("idle_after_ovr", o_valid, 1'b0);
    done = 1'b0;
    tick();

    // Rise coinciding with the last accept: overrun, back to idle
    base = acc_cnt;
    push_matrix();
    done = 1'b1;
    tick();
    wait_accepts(base + 8, 20, "pre_last_count");
    ready = 1'b0;
    done  = 1'b0;
    tick();
    ready = 1'b1;
    done  = 1'b1;
    tick();
    chk("last_ovr_pulse", o_overrun, 1'b1);
    chk("last_ovr_idle", o_valid, 1'b0);
    repeat (5) tick();
    chk("last_ovr_norestart", o_valid, 1'b0);
    chk("last_ovr_count", acc_cnt, base + 9);
    done = 1'b0;
    tick();

    // 5: reset mid-stream at beat 5, then a fresh stream
    base = acc_cnt;
    push_matrix();
    done = 1'b1;
    tick();
    wait_accepts(base + 5, 20, "pre_rst_count");
    rst_n = 1'b0;
    ready = 1'b0;
    done  = 1'b0;
    tick();
    chk("mid_rst_valid", o_valid, 1'b0);
    chk("mid_rst_busy", o_busy, 1'b0);
    chk("mid_rst_left", exp_q.size(), 4);
    exp_q.delete();
    rst_n = 1'b1;
    tick();
    base = acc_cnt;
    push_matrix();
    ready = 1'b1;
    done  = 1'b1;
    tick();
    chk("post_rst_valid", o_valid, 1'b1);
    chk("post_rst_origin", {o_row, o_col}, '0);
    wait_accepts(base + 9, 20, "post_rst_count");
    done = 1'b0;
    repeat (3) tick();

    chk("ovr_total", ovr_cnt, 2);
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
